// File: rtl/systolic_feeder.sv
// ---------------------------------------------------------------------------
// systolic_feeder
//
// Transmit side of the systolic MAC-array edge interface. Buffers one N x N
// operand pair (A, B) beat by beat, then drives the array's west and north
// edges with diagonally skewed, zero-filled streams. It also generates the
// array clear pulse, the accumulate enable and a completion pulse.
//
// Optional feature: define SYSTOLIC_FEED_PERF_EN to add the perf_jobs output.
// perf_jobs is a saturating count of completed jobs.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset
//   in_valid   load beat valid
//   in_ready   feeder can accept a load beat (high only in LOAD)
//   in_a       beat k: lane i = A[i][k]
//   in_b       beat k: lane j = B[k][j]
//   west_out   lane i drives the west input of PE(i,0)
//   north_out  lane j drives the north input of PE(0,j)
//   arr_start  array accumulate enable (high for the 3N-2 RUN cycles)
//   arr_clr    one-cycle accumulator clear (active-high)
//   busy       high in CLEAR, RUN and DONE
//   perf_jobs  (SYSTOLIC_FEED_PERF_EN only) saturating completed-job count
//   done       one-cycle pulse when the array results are final
// Lane x occupies bits [x*WIDTH +: WIDTH] on every bus.
// ---------------------------------------------------------------------------
module systolic_feeder #(
  parameter int WIDTH = 16,
  parameter int N     = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N*WIDTH-1:0] in_a,
  input  logic [N*WIDTH-1:0] in_b,
  output logic [N*WIDTH-1:0] west_out,
  output logic [N*WIDTH-1:0] north_out,
  output logic               arr_start,
  output logic               arr_clr,
  output logic               busy,
`ifdef SYSTOLIC_FEED_PERF_EN
  output logic [15:0]        perf_jobs,
`endif
  output logic               done
);

  localparam int BW      = (N > 1) ? $clog2(N) : 1;
  localparam int RUN_LEN = 3 * N - 2;
  localparam int TW      = $clog2(RUN_LEN);

  localparam logic [BW-1:0] LAST_BEAT = BW'(N - 1);
  localparam logic [TW-1:0] LAST_T    = TW'(RUN_LEN - 1);

  typedef enum logic [1:0] {
    S_LOAD,
    S_CLEAR,
    S_RUN,
    S_DONE
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [BW-1:0]     beat_cnt;
  logic [BW-1:0]     beat_nxt;
  logic [TW-1:0]     t_cnt;
  logic [TW-1:0]     t_nxt;
  logic              accept;
  logic [N*WIDTH-1:0] west_nxt;
  logic [N*WIDTH-1:0] north_nxt;

  // a_buf[i][k] = A[i][k], b_buf[k][j] = B[k][j]
  logic [WIDTH-1:0]  a_buf [N][N];
  logic [WIDTH-1:0]  b_buf [N][N];

  // in_ready is itself a register that tracks "state is LOAD", so gating the
  // handshake with it is enough to ignore in_valid in every other state.
  assign accept = (state == S_LOAD) && in_valid && in_ready;

  // State, beat counter and RUN cycle counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= S_LOAD;
      beat_cnt <= '0;
      t_cnt    <= '0;
    end else begin
      state    <= state_nxt;
      beat_cnt <= beat_nxt;
      t_cnt    <= t_nxt;
    end
  end

  // Next-state logic. The RUN counter restarts at 0 on entry to RUN.
  // The beat counter returns to 0 on the Nth accepted beat.
  always_comb begin
    state_nxt = state;
    beat_nxt  = beat_cnt;
    t_nxt     = t_cnt;
    case (state)
      S_LOAD: begin
        if (accept) begin
          if (beat_cnt == LAST_BEAT) begin
            state_nxt = S_CLEAR;
            beat_nxt  = '0;
          end else begin
            beat_nxt = beat_cnt + BW'(1);
          end
        end
      end
      S_CLEAR: begin
        state_nxt = S_RUN;
        t_nxt     = '0;
      end
      S_RUN: begin
        if (t_cnt == LAST_T) begin
          state_nxt = S_DONE;
          t_nxt     = '0;
        end else begin
          t_nxt = t_cnt + TW'(1);
        end
      end
      S_DONE: begin
        state_nxt = S_LOAD;
        beat_nxt  = '0;
      end
      default: begin
        state_nxt = S_LOAD;
        beat_nxt  = '0;
        t_nxt     = '0;
      end
    endcase
  end

  // The edge values for the upcoming cycle are built from the next state
  // and the next RUN index. Registering them then lines the outputs up
  // exactly with the state. Lane i is delayed by i cycles to form the
  // diagonal skew. Anything outside the operand window is forced to zero,
  // which keeps the PE accumulators from picking up trailing products.
  always_comb begin
    int               d;
    logic [BW-1:0]    idx;
    west_nxt  = '0;
    north_nxt = '0;
    d         = 0;
    idx       = '0;
    if (state_nxt == S_RUN) begin
      for (int i = 0; i < N; i++) begin
        d = int'(t_nxt) - i;
        if (d >= 0 && d < N) begin
          idx = d[BW-1:0];
          west_nxt[i*WIDTH +: WIDTH]  = a_buf[i][idx];
          north_nxt[i*WIDTH +: WIDTH] = b_buf[idx][i];
        end
      end
    end
  end

  // Registered outputs. Each one is a decode of the next state, so its value
  // is valid in the same cycle as the state it describes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      in_ready  <= 1'b0;
      arr_clr   <= 1'b0;
      arr_start <= 1'b0;
      done      <= 1'b0;
      busy      <= 1'b0;
      west_out  <= '0;
      north_out <= '0;
    end else begin
      in_ready  <= (state_nxt == S_LOAD);
      arr_clr   <= (state_nxt == S_CLEAR);
      arr_start <= (state_nxt == S_RUN);
      done      <= (state_nxt == S_DONE);
      busy      <= (state_nxt != S_LOAD);
      west_out  <= west_nxt;
      north_out <= north_nxt;
    end
  end

  // Operand buffers have no reset: a reset leaves stale data in place, and
  // the next job overwrites every entry before it is streamed.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N; i++) begin
        a_buf[i][beat_cnt] <= in_a[i*WIDTH +: WIDTH];
        b_buf[beat_cnt][i] <= in_b[i*WIDTH +: WIDTH];
      end
    end
  end

`ifdef SYSTOLIC_FEED_PERF_EN
  // Completed-job counter. It steps on entry to DONE, so the new count is
  // visible in the same cycle as the done pulse. It holds at all-ones.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_jobs <= '0;
    end else if (state_nxt == S_DONE && perf_jobs != 16'hFFFF) begin
      perf_jobs <= perf_jobs + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_systolic_feeder.sv
// ---------------------------------------------------------------------------
// tb_systolic_feeder
//
// Self-checking bench for systolic_feeder (N=2, WIDTH=16).
// Each edge value is predicted straight from the skew formula applied to the
// A/B matrices held in the bench. A behavioural 2x2 PE grid consumes the DUT
// edges, and its accumulators are compared with a plain matrix product.
// ---------------------------------------------------------------------------
module tb_systolic_feeder;

  localparam int W = 16;
  localparam int N = 2;

  logic           clk;
  logic           rst;
  logic           in_valid;
  logic           in_ready;
  logic [N*W-1:0] in_a;
  logic [N*W-1:0] in_b;
  logic [N*W-1:0] west_out;
  logic [N*W-1:0] north_out;
  logic           arr_start;
  logic           arr_clr;
  logic           busy;
  logic           done;
`ifdef SYSTOLIC_FEED_PERF_EN
  logic [15:0]    perf_jobs;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int jobs_since_reset = 0;

  // Reference matrices for the job being loaded and streamed
  logic [W-1:0] ma [N][N];
  logic [W-1:0] mb [N][N];

  // Behavioural PE grid state
  longint unsigned acc  [N][N];
  logic [W-1:0]    wreg [N][N];
  logic [W-1:0]    nreg [N][N];

  systolic_feeder #(.WIDTH(W), .N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .west_out  (west_out),
    .north_out (north_out),
    .arr_start (arr_start),
    .arr_clr   (arr_clr),
    .busy      (busy),
`ifdef SYSTOLIC_FEED_PERF_EN
    .perf_jobs (perf_jobs),
`endif
    .done      (done)
  );

  // Free-running clock, 10 time-unit period
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural 2-D systolic grid attached to the feeder edges. Each PE
  // multiplies the operands in front of it and then hands them east and
  // south. Columns and rows are walked from high to low, so every PE reads
  // its neighbour's value from the previous cycle.
  always @(negedge clk) begin
    logic [W-1:0] w_in;
    logic [W-1:0] n_in;
    if (arr_clr) begin
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          acc[i][j] = 0;
    end
    for (int i = N - 1; i >= 0; i--) begin
      for (int j = N - 1; j >= 0; j--) begin
        w_in = (j == 0) ? west_out[i*W +: W] : wreg[i][j-1];
        n_in = (i == 0) ? north_out[j*W +: W] : nreg[i-1][j];
        if (arr_start)
          acc[i][j] = acc[i][j] + longint'(w_in) * longint'(n_in);
        wreg[i][j] = w_in;
        nreg[i][j] = n_in;
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N*W-1:0] exp_west(input int t);
    logic [N*W-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++)
      if (t - i >= 0 && t - i < N) r[i*W +: W] = ma[i][t-i];
    return r;
  endfunction

  function automatic logic [N*W-1:0] exp_north(input int t);
    logic [N*W-1:0] r;
    r = '0;
    for (int j = 0; j < N; j++)
      if (t - j >= 0 && t - j < N) r[j*W +: W] = mb[t-j][j];
    return r;
  endfunction

  function automatic longint unsigned exp_prod(input int i, input int j);
    longint unsigned s;
    s = 0;
    for (int k = 0; k < N; k++) s += longint'(ma[i][k]) * longint'(mb[k][j]);
    return s;
  endfunction

  function automatic logic [N*W-1:0] rand_bus();
    logic [N*W-1:0] r;
    for (int i = 0; i < N; i++) r[i*W +: W] = W'($urandom);
    return r;
  endfunction

  // mode 0: random, 1: all-ones (widest products), 2: random with zeros mixed in
  task automatic fill_matrices(input int mode);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++) begin
        ma[i][j] = (mode == 1) ? 16'hFFFF : W'($urandom);
        mb[i][j] = (mode == 1) ? 16'hFFFF : W'($urandom);
        if (mode == 2 && $urandom_range(0, 1) == 0) ma[i][j] = '0;
      end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"},      busy,      1'b0);
    check({tag, "_in_ready"},  in_ready,  1'b1);
    check({tag, "_done"},      done,      1'b0);
    check({tag, "_arr_start"}, arr_start, 1'b0);
  endtask

  // Loads the current ma/mb and follows one job through CLEAR, RUN and DONE.
  // The task is entered and left at a negedge while the DUT is in LOAD, so
  // calls placed one after another run as back-to-back jobs.
  //   gaps     : in_valid alternates 1,0,1,... during the load
  //   junk     : in_valid held high with random data outside LOAD
  //   abort_t  : reset asserted at that RUN cycle (-1 = never)
  task automatic apply_stimulus(input string tag, input bit gaps, input bit junk, input int abort_t);
    int k;
    int cyc;
    k   = 0;
    cyc = 0;
    while (k < N && cyc < 4 * N) begin
      in_valid = gaps ? (cyc % 2 == 0) : 1'b1;
      for (int i = 0; i < N; i++) begin
        in_a[i*W +: W] = ma[i][k];
        in_b[i*W +: W] = mb[k][i];
      end
      check({tag, "_load_ready"}, in_ready, 1'b1);
      @(negedge clk);
      if (in_valid) k++;
      cyc++;
    end
    check({tag, "_beats_loaded"}, k, N);

    // CLEAR cycle
    in_valid = junk;
    if (junk) begin
      in_a = rand_bus();
      in_b = rand_bus();
    end
    check({tag, "_clr"},       arr_clr,   1'b1);
    check({tag, "_clr_start"}, arr_start, 1'b0);
    check({tag, "_clr_ready"}, in_ready,  1'b0);
    check({tag, "_clr_busy"},  busy,      1'b1);
    check({tag, "_clr_west"},  west_out,  '0);

    for (int t = 0; t < 3 * N - 2; t++) begin
      @(negedge clk);
      if (junk) begin
        in_a = rand_bus();
        in_b = rand_bus();
      end
      check($sformatf("%s_t%0d_west", tag, t),  west_out,  exp_west(t));
      check($sformatf("%s_t%0d_north", tag, t), north_out, exp_north(t));
      check($sformatf("%s_t%0d_start", tag, t), arr_start, 1'b1);
      check($sformatf("%s_t%0d_clr", tag, t),   arr_clr,   1'b0);
      check($sformatf("%s_t%0d_ready", tag, t), in_ready,  1'b0);
      check($sformatf("%s_t%0d_done", tag, t),  done,      1'b0);
      if (t == abort_t) begin
        rst      = 1'b0;
        in_valid = 1'b0;
        #1;
        check({tag, "_arst_west"},  west_out,  '0);
        check({tag, "_arst_north"}, north_out, '0);
        check({tag, "_arst_start"}, arr_start, 1'b0);
        check({tag, "_arst_busy"},  busy,      1'b0);
        check({tag, "_arst_done"},  done,      1'b0);
        check({tag, "_arst_clr"},   arr_clr,   1'b0);
        jobs_since_reset = 0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check_idle({tag, "_after_rst"});
        return;
      end
    end

    // DONE cycle
    @(negedge clk);
    check({tag, "_done"},       done,      1'b1);
    check({tag, "_done_start"}, arr_start, 1'b0);
    check({tag, "_done_busy"},  busy,      1'b1);
    check({tag, "_done_ready"}, in_ready,  1'b0);
    check({tag, "_done_west"},  west_out,  '0);
    check({tag, "_done_north"}, north_out, '0);
    jobs_since_reset++;
    check_output(tag);

    @(negedge clk);
    in_valid = 1'b0;
    check_idle({tag, "_post"});
  endtask

  // Compares the behavioural PE grid against the plain matrix product
  task automatic check_output(input string tag);
    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        check($sformatf("%s_C%0d%0d", tag, i, j), acc[i][j], exp_prod(i, j));
  endtask

  // Directed and random job sequence
  initial begin
    rst      = 1'b0;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    #1;
    check("rst_west",      west_out,  '0);
    check("rst_north",     north_out, '0);
    check("rst_busy",      busy,      1'b0);
    check("rst_done",      done,      1'b0);
    check("rst_arr_clr",   arr_clr,   1'b0);
    check("rst_arr_start", arr_start, 1'b0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check_idle("rel");

    $display("[TB] directed 2x2 job");
    ma[0][0] = 16'd1; ma[0][1] = 16'd2; ma[1][0] = 16'd3; ma[1][1] = 16'd4;
    mb[0][0] = 16'd5; mb[0][1] = 16'd6; mb[1][0] = 16'd7; mb[1][1] = 16'd8;
    apply_stimulus("dir", 1'b0, 1'b0, -1);
    check("dir_C00_const", acc[0][0], 64'd19);
    check("dir_C01_const", acc[0][1], 64'd22);
    check("dir_C10_const", acc[1][0], 64'd43);
    check("dir_C11_const", acc[1][1], 64'd50);

    $display("[TB] handshake gaps");
    fill_matrices(0);
    apply_stimulus("gap", 1'b1, 1'b0, -1);

    $display("[TB] in_valid held outside LOAD");
    fill_matrices(2);
    apply_stimulus("junk", 1'b0, 1'b1, -1);

    $display("[TB] reset mid-RUN then fresh job");
    fill_matrices(0);
    apply_stimulus("abort", 1'b0, 1'b0, 1);
    fill_matrices(0);
    apply_stimulus("fresh", 1'b0, 1'b0, -1);

    $display("[TB] back-to-back random jobs");
    fill_matrices(1);
    apply_stimulus("b2b_max", 1'b0, 1'b0, -1);
    for (int r = 0; r < 3; r++) begin
      fill_matrices(r % 3);
      apply_stimulus($sformatf("b2b_%0d", r), r[0], 1'b0, -1);
    end

`ifdef SYSTOLIC_FEED_PERF_EN
    check("perf_jobs", perf_jobs, jobs_since_reset);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/systolic_feeder.md
Name: systolic_feeder

Overview:
- Transmit side of the systolic MAC-array edge interface: buffers one N x N operand pair (A, B), then drives the array's west and north edges with diagonally skewed streams.
- Generates the array's start enable and clear pulse, and signals completion.
- Sits between the DMA/load path and an N x N grid of PE tiles; PE(i,0) west inputs come from west lane i, PE(0,j) north inputs come from north lane j.

Parameters:
- WIDTH, 16, operand width per lane (matches PE WIDTH)
- N, 4, array dimension (rows = cols = K); legal range 2..16

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  load beat valid
- in_ready  output  1  feeder can accept a load beat
- in_a  input  N*WIDTH  beat k: lane i = A[i][k]
- in_b  input  N*WIDTH  beat k: lane j = B[k][j]
- west_out  output  N*WIDTH  lane i to PE(i,0) west input
- north_out  output  N*WIDTH  lane j to PE(0,j) north input
- arr_start  output  1  array accumulate enable
- arr_clr  output  1  one-cycle clear for the PE accumulators (active-high, integrator ORs it into the PE reset)
- busy  output  1  high in any state other than LOAD
- done  output  1  one-cycle pulse when array results are final

Behaviour:
- Lane x occupies bits [x*WIDTH +: WIDTH] on every bus.
- All outputs are registered.
- Reset (rst low, any time including mid-RUN):
  - state = LOAD, beat count = 0, buffers keep stale data.
  - west_out = 0, north_out = 0, arr_start = 0, arr_clr = 0, done = 0, busy = 0, in_ready = 1 after release.
- LOAD:
  - in_ready = 1.
  - A beat is accepted when in_valid && in_ready; beat k (k = 0..N-1, in arrival order) is stored into buffer column/row k.
  - The Nth accepted beat moves the state to CLEAR next cycle; in_ready is low from that cycle on.
  - in_valid outside LOAD is ignored; no data is captured.
- CLEAR: exactly 1 cycle; arr_clr = 1, arr_start = 0, edges = 0.
- RUN: exactly 3N-2 cycles, numbered t = 0..3N-3.
  - arr_start = 1 throughout.
  - west lane i = A[i][t-i] if 0 <= t-i < N, else 0.
  - north lane j = B[t-j][j] if 0 <= t-j < N, else 0.
  - Zero fill is mandatory so the PE accumulators remain unaffected after the last operand.
  - The last operand pair reaches PE(N-1,N-1) at t = 3N-3.
- DONE: 1 cycle; done = 1, arr_start = 0, edges = 0; next state LOAD with beat count = 0.
- busy = 1 in CLEAR, RUN and DONE.
- Back-to-back jobs:
  - The first beat of the next job may be accepted in the cycle after DONE.
  - Minimum job period = N + 1 + (3N-2) + 1 cycles.
- Counters:
  - Beat and RUN counters are sized for their maximum values; no wrap occurs within a job.
  - Unused counter bits are ignored.
- No arithmetic on data; operands pass through unmodified (no sign handling).

Optional Feature:
- Macro: SYSTOLIC_FEED_PERF_EN.
- Defined: adds output perf_jobs (16 bits).
  - Increments in the DONE cycle and saturates at 16'hFFFF.
  - Reset to 0 by rst.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
- N=2, WIDTH=16, A=[[1,2],[3,4]], B=[[5,6],[7,8]]: load beats in_a={3,1},{4,2} and in_b={6,5},{8,7}.
  - Required edges, t0..t3 (west lanes 0/1, north lanes 0/1): t0 west 1/0, north 5/0; t1 west 2/3, north 7/6; t2 west 0/4, north 0/8; t3 all 0.
  - With attached 2x2 PE array, results after done = 19, 22, 43, 50.
- Handshake gaps: in_valid toggled 1,0,1 over three cycles.
  - Exactly 2 beats captured.
  - in_ready drops the cycle after the 2nd beat.
  - arr_clr pulses once, then arr_start is high for exactly 4 cycles, then done pulses once.
- in_valid held high with distinct data during CLEAR/RUN/DONE: in_ready = 0 throughout, and the streamed values equal the first job's data.
- rst low at RUN t=1: all outputs 0 immediately (asynchronous); after release busy = 0 and in_ready = 1; a fresh job then produces correct results.
- Two jobs back-to-back with different matrices: second job's first beat is accepted the cycle after done; second results are not contaminated by the first (arr_clr observed before the second RUN).
- SYSTOLIC_FEED_PERF_EN defined, 3 jobs run: perf_jobs = 3; a preloaded near-saturation count stays at 16'hFFFF after further jobs.
